// File: rtl/mmio_pkg.sv
// Shared constants and the status-word packing helper for the MMIO I/O port.
package mmio_pkg;

  // Default addresses of the three reserved data-memory locations.
  localparam logic [15:0] IN_ADDR   = 16'hFFF0;
  localparam logic [15:0] STAT_ADDR = 16'hFFF2;
  localparam logic [15:0] OUT_ADDR  = 16'hFFF4;

  // Bit positions inside the status word.
  localparam int ST_RXNE    = 0;
  localparam int ST_TXFULL  = 1;
  localparam int ST_RXOVF   = 2;
  localparam int ST_TXDROP  = 3;
  localparam int ST_CNT_LSB = 8;

  // Build the status word; every bit not named here reads as zero.
  function automatic logic [15:0] pack_status(input logic       rx_nonempty,
                                              input logic       tx_full,
                                              input logic       rx_ovf,
                                              input logic       tx_drop,
                                              input logic [7:0] rx_count);
    logic [15:0] s;
    s                    = 16'h0000;
    s[ST_RXNE]           = rx_nonempty;
    s[ST_TXFULL]         = tx_full;
    s[ST_RXOVF]          = rx_ovf;
    s[ST_TXDROP]         = tx_drop;
    s[ST_CNT_LSB +: 8]   = rx_count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_io_port_if.sv
// Processor data-bus and host valid/ready signals of the MMIO I/O port.
interface mmio_io_port_if;

  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic        bus_hit;
  logic [15:0] bus_rdata;
  logic [15:0] host_in_data;
  logic        host_in_valid;
  logic        host_in_ready;
  logic [15:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready;
  logic [15:0] main_output;

  // Side that drives the processor bus and the host.
  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re,
    output host_in_data, host_in_valid, host_out_ready,
    input  bus_hit, bus_rdata, host_in_ready,
    input  host_out_data, host_out_valid, main_output
  );

  // The I/O port itself.
  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re,
    input  host_in_data, host_in_valid, host_out_ready,
    output bus_hit, bus_rdata, host_in_ready,
    output host_out_data, host_out_valid, main_output
  );

endinterface

// File: rtl/io_fifo.sv
// Synchronous circular FIFO with a registered occupancy count.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Next storage, pointers (wrapping modulo DEPTH) and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO state register; reset empties the FIFO and clears storage.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_io_port.sv
// Memory-mapped I/O responder: decodes three reserved data addresses,
// moves words between the processor and the host through RX/TX FIFOs,
// keeps sticky overflow/drop flags and mirrors the last OUT_ADDR store.
module mmio_io_port
  import mmio_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] IN_ADDR   = mmio_pkg::IN_ADDR,
  parameter logic [15:0] STAT_ADDR = mmio_pkg::STAT_ADDR,
  parameter logic [15:0] OUT_ADDR  = mmio_pkg::OUT_ADDR
) (
  input logic           CLK,
  input logic           Reset,
  mmio_io_port_if.slave io
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic          in_hit_s, stat_hit_s, out_hit_s;
  logic          load_s, out_store_s, stat_store_s;
  logic          rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic          tx_push_s, tx_pop_s, tx_full_s, tx_empty_s, tx_room_s;
  logic [15:0]   rx_dout_s, tx_dout_s;
  logic [CW-1:0] rx_count_s, tx_count_s;
  logic          rx_ovf_set_s, rx_ovf_clr_s, tx_drop_set_s, tx_drop_clr_s;

  logic [15:0]   rdata_q, rdata_d;
  logic [15:0]   main_q, main_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          tx_drop_q, tx_drop_d;

  assign in_hit_s   = (io.bus_addr == IN_ADDR);
  assign stat_hit_s = (io.bus_addr == STAT_ADDR);
  assign out_hit_s  = (io.bus_addr == OUT_ADDR);

  // A store and a load in the same cycle: the store wins, the load is void.
  assign load_s       = io.bus_re && !io.bus_we;
  assign out_store_s  = io.bus_we && out_hit_s;
  assign stat_store_s = io.bus_we && stat_hit_s;

  // TX acceptance judged on the start-of-cycle count, so a same-cycle host
  // pop never rescues a store into a full FIFO.
  assign tx_room_s = (tx_count_s != CNT_MAX);

  assign rx_push_s = io.host_in_valid && !rx_full_s;
  assign rx_pop_s  = load_s && in_hit_s && !rx_empty_s;
  assign tx_push_s = out_store_s && tx_room_s;
  assign tx_pop_s  = io.host_out_ready && !tx_empty_s;

  assign rx_ovf_set_s  = io.host_in_valid && rx_full_s;
  assign rx_ovf_clr_s  = stat_store_s && io.bus_wdata[ST_RXOVF];
  assign tx_drop_set_s = out_store_s && !tx_room_s;
  assign tx_drop_clr_s = stat_store_s && io.bus_wdata[ST_TXDROP];

  assign io.bus_hit        = in_hit_s || stat_hit_s || out_hit_s;
  assign io.bus_rdata      = rdata_q;
  assign io.host_in_ready  = !rx_full_s;
  assign io.host_out_data  = tx_dout_s;
  assign io.host_out_valid = !tx_empty_s;
  assign io.main_output    = main_q;

  io_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_rx_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (rx_push_s),
    .pop   (rx_pop_s),
    .din   (io.host_in_data),
    .dout  (rx_dout_s),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_s)
  );

  io_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_tx_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (tx_push_s),
    .pop   (tx_pop_s),
    .din   (io.bus_wdata),
    .dout  (tx_dout_s),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_s)
  );

  // Sticky flags: a set in the same cycle as a clear takes priority.
  always_comb begin
    rx_ovf_d  = rx_ovf_q;
    tx_drop_d = tx_drop_q;
    if (rx_ovf_set_s) begin
      rx_ovf_d = 1'b1;
    end else if (rx_ovf_clr_s) begin
      rx_ovf_d = 1'b0;
    end else begin
      rx_ovf_d = rx_ovf_q;
    end
    if (tx_drop_set_s) begin
      tx_drop_d = 1'b1;
    end else if (tx_drop_clr_s) begin
      tx_drop_d = 1'b0;
    end else begin
      tx_drop_d = tx_drop_q;
    end
  end

  // Load data: captured on a load cycle, held otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (io.bus_re && io.bus_we) begin
      rdata_d = 16'h0000;
    end else if (io.bus_re) begin
      if (in_hit_s) begin
        rdata_d = rx_empty_s ? 16'h0000 : rx_dout_s;
      end else if (stat_hit_s) begin
        rdata_d = pack_status(!rx_empty_s, tx_full_s, rx_ovf_q, tx_drop_q,
                              8'(rx_count_s));
      end else begin
        rdata_d = 16'h0000;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Output mirror follows every OUT_ADDR store, even a dropped one.
  always_comb begin
    main_d = main_q;
    if (out_store_s) begin
      main_d = io.bus_wdata;
    end else begin
      main_d = main_q;
    end
  end

  // Registered load data, output mirror and sticky flags.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rdata_q   <= 16'h0000;
      main_q    <= 16'h0000;
      rx_ovf_q  <= 1'b0;
      tx_drop_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      main_q    <= main_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_drop_q <= tx_drop_d;
    end
  end

endmodule

// File: tb/tb_mmio_io_port.sv
// Self-checking bench for mmio_io_port: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_mmio_io_port;
  import mmio_pkg::*;

  localparam int DEPTH = 4;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  mmio_io_port_if io ();

  mmio_io_port #(.DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .io    (io)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] rxq[$];
  logic [15:0] txq[$];
  bit          m_ovf, m_drop;
  logic [15:0] m_rdata, m_main;
  int          m_rxn, m_txn;
  logic [15:0] m_stat;
  bit          m_ovf_set, m_drop_set;

  // Advance the model one clock using start-of-cycle occupancy.
  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rxq.delete();
      txq.delete();
      m_ovf   = 1'b0;
      m_drop  = 1'b0;
      m_rdata = 16'h0000;
      m_main  = 16'h0000;
    end else begin
      m_rxn      = rxq.size();
      m_txn      = txq.size();
      m_stat     = {8'(m_rxn), 4'h0, m_drop, m_ovf, (m_txn == DEPTH), (m_rxn != 0)};
      m_ovf_set  = 1'b0;
      m_drop_set = 1'b0;
      if (io.bus_re && io.bus_we) m_rdata = 16'h0000;
      else if (io.bus_re) begin
        if (io.bus_addr == IN_ADDR) m_rdata = (m_rxn > 0) ? rxq.pop_front() : 16'h0000;
        else if (io.bus_addr == STAT_ADDR) m_rdata = m_stat;
        else m_rdata = 16'h0000;
      end
      if (io.host_in_valid) begin
        if (m_rxn < DEPTH) rxq.push_back(io.host_in_data);
        else m_ovf_set = 1'b1;
      end
      if (io.host_out_ready && m_txn > 0) void'(txq.pop_front());
      if (io.bus_we && io.bus_addr == OUT_ADDR) begin
        m_main = io.bus_wdata;
        if (m_txn < DEPTH) txq.push_back(io.bus_wdata);
        else m_drop_set = 1'b1;
      end
      if (io.bus_we && io.bus_addr == STAT_ADDR) begin
        if (io.bus_wdata[2]) m_ovf = 1'b0;
        if (io.bus_wdata[3]) m_drop = 1'b0;
      end
      if (m_ovf_set)  m_ovf = 1'b1;
      if (m_drop_set) m_drop = 1'b1;
    end
  end

  // Compare DUT outputs against the model shortly after every rising edge.
  always @(posedge CLK) begin
    #2;
    if (!Reset) begin
      chk("rdata", io.bus_rdata, m_rdata);
      chk("main_output", io.main_output, m_main);
      chk("host_in_ready", {15'd0, io.host_in_ready}, {15'd0, (rxq.size() < DEPTH)});
      chk("host_out_valid", {15'd0, io.host_out_valid}, {15'd0, (txq.size() != 0)});
      if (txq.size() != 0) chk("host_out_data", io.host_out_data, txq[0]);
      chk("bus_hit", {15'd0, io.bus_hit},
          {15'd0, (io.bus_addr == IN_ADDR || io.bus_addr == STAT_ADDR || io.bus_addr == OUT_ADDR)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle();
    io.bus_addr       = 16'h0000;
    io.bus_wdata      = 16'h0000;
    io.bus_we         = 1'b0;
    io.bus_re         = 1'b0;
    io.host_in_data   = 16'h0000;
    io.host_in_valid  = 1'b0;
    io.host_out_ready = 1'b0;
  endtask

  task automatic bus_load(input logic [15:0] a);
    io.bus_addr = a;
    io.bus_re   = 1'b1;
    io.bus_we   = 1'b0;
    tick();
    io.bus_re   = 1'b0;
  endtask

  task automatic bus_store(input logic [15:0] a, input logic [15:0] d);
    io.bus_addr  = a;
    io.bus_wdata = d;
    io.bus_we    = 1'b1;
    io.bus_re    = 1'b0;
    tick();
    io.bus_we    = 1'b0;
  endtask

  task automatic host_push(input logic [15:0] d);
    io.host_in_data  = d;
    io.host_in_valid = 1'b1;
    tick();
    io.host_in_valid = 1'b0;
  endtask

  task automatic host_pop_check(input string name, input logic [15:0] exp);
    chk(name, io.host_out_data, exp);
    io.host_out_ready = 1'b1;
    tick();
    io.host_out_ready = 1'b0;
  endtask

  logic [15:0] exp_tx[4];
  int r;

  initial begin
    idle();
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    tick();

    // Reset state
    chk("rst_rdata", io.bus_rdata, 16'h0000);
    chk("rst_main", io.main_output, 16'h0000);
    chk("rst_out_valid", {15'd0, io.host_out_valid}, 16'h0000);
    chk("rst_in_ready", {15'd0, io.host_in_ready}, 16'h0001);
    bus_load(STAT_ADDR);
    chk("rst_stat", io.bus_rdata, 16'h0000);

    // RX basic ordering and empty load
    host_push(16'h1234);
    host_push(16'h5678);
    bus_load(IN_ADDR);
    chk("rx_first", io.bus_rdata, 16'h1234);
    bus_load(IN_ADDR);
    chk("rx_second", io.bus_rdata, 16'h5678);
    bus_load(IN_ADDR);
    chk("rx_empty_load", io.bus_rdata, 16'h0000);
    bus_load(STAT_ADDR);
    chk("rx_empty_stat", io.bus_rdata, 16'h0000);

    // RX overflow and flag clear
    for (int i = 0; i < 4; i++) host_push(16'h00A0 + 16'(i));
    chk("rx_full_ready", {15'd0, io.host_in_ready}, 16'h0000);
    host_push(16'h00A4);
    bus_load(STAT_ADDR);
    chk("rx_ovf_stat", io.bus_rdata, 16'h0405);
    bus_store(STAT_ADDR, 16'h0004);
    bus_load(STAT_ADDR);
    chk("rx_ovf_clr", io.bus_rdata, 16'h0401);
    for (int i = 0; i < 4; i++) begin
      bus_load(IN_ADDR);
      chk("rx_intact", io.bus_rdata, 16'h00A0 + 16'(i));
    end

    // TX fill with drop, then drain
    exp_tx = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    for (int i = 0; i < 4; i++) bus_store(OUT_ADDR, exp_tx[i]);
    bus_store(OUT_ADDR, 16'hEEEE);
    bus_load(STAT_ADDR);
    chk("tx_drop_stat", io.bus_rdata, 16'h000A);
    chk("tx_main", io.main_output, 16'hEEEE);
    for (int i = 0; i < 4; i++) host_pop_check("tx_drain", exp_tx[i]);
    chk("tx_drained", {15'd0, io.host_out_valid}, 16'h0000);
    bus_store(STAT_ADDR, 16'h0008);
    bus_load(STAT_ADDR);
    chk("tx_drop_clr", io.bus_rdata, 16'h0000);

    // Store into full TX coinciding with a host pop is still dropped
    for (int i = 1; i <= 4; i++) bus_store(OUT_ADDR, 16'h0011 * 16'(i));
    io.host_out_ready = 1'b1;
    bus_store(OUT_ADDR, 16'h9999);
    io.host_out_ready = 1'b0;
    chk("race_valid", {15'd0, io.host_out_valid}, 16'h0001);
    chk("race_main", io.main_output, 16'h9999);
    bus_load(STAT_ADDR);
    chk("race_stat", io.bus_rdata, 16'h0008);
    for (int i = 2; i <= 4; i++) host_pop_check("race_drain", 16'h0011 * 16'(i));
    chk("race_empty", {15'd0, io.host_out_valid}, 16'h0000);
    bus_store(STAT_ADDR, 16'h000C);

    // Asynchronous reset with traffic held
    host_push(16'h0C01);
    host_push(16'h0C02);
    for (int i = 0; i < 3; i++) bus_store(OUT_ADDR, 16'h0D00 + 16'(i));
    bus_load(STAT_ADDR);
    chk("pre_rst_stat", io.bus_rdata, 16'h0201);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_rdata", io.bus_rdata, 16'h0000);
    chk("arst_main", io.main_output, 16'h0000);
    chk("arst_out_valid", {15'd0, io.host_out_valid}, 16'h0000);
    chk("arst_in_ready", {15'd0, io.host_in_ready}, 16'h0001);
    tick();
    Reset = 1'b0;
    bus_load(STAT_ADDR);
    chk("post_rst_stat", io.bus_rdata, 16'h0000);

    // Sustained push + pop across pointer wrap-around
    host_push(16'h0100);
    host_push(16'h0101);
    for (int i = 0; i < 20; i++) begin
      io.host_in_data  = 16'h0102 + 16'(i);
      io.host_in_valid = 1'b1;
      io.bus_addr      = IN_ADDR;
      io.bus_re        = 1'b1;
      tick();
      chk("stream_data", io.bus_rdata, 16'h0100 + 16'(i));
      chk("stream_ready", {15'd0, io.host_in_ready}, 16'h0001);
    end
    idle();
    bus_load(STAT_ADDR);
    chk("stream_count", io.bus_rdata, 16'h0201);
    bus_load(IN_ADDR);
    chk("stream_tail0", io.bus_rdata, 16'h0114);
    bus_load(IN_ADDR);
    chk("stream_tail1", io.bus_rdata, 16'h0115);

    // Random traffic, model-checked every cycle, with one async reset
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 4);
      case (r)
        0, 4:    io.bus_addr = IN_ADDR;
        1:       io.bus_addr = STAT_ADDR;
        2:       io.bus_addr = OUT_ADDR;
        default: io.bus_addr = 16'($urandom);
      endcase
      io.bus_wdata      = 16'($urandom);
      io.bus_we         = ($urandom_range(0, 3) == 0);
      io.bus_re         = ($urandom_range(0, 2) == 0);
      io.host_in_data   = 16'($urandom);
      io.host_in_valid  = ($urandom_range(0, 1) == 1);
      io.host_out_ready = ($urandom_range(0, 2) == 0);
      if (i == 300) begin
        #3;
        Reset = 1'b1;
        #1;
        chk("rand_arst_rdata", io.bus_rdata, 16'h0000);
        tick();
        Reset = 1'b0;
      end else begin
        tick();
      end
    end
    idle();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_io_port.md
Name: mmio_io_port

Overview:
- Memory-mapped I/O responder for the 16-bit multi-cycle processor.
- Decodes the processor's data-memory bus (address, write data, read/write strobes) and answers accesses to three reserved addresses.
- Buffers host-to-processor words in an RX FIFO and processor-to-host words in a TX FIFO, both with valid/ready handshakes on the host side.
- Also drives the 16-bit main_output mirror of the last word the processor wrote.

Parameters:
- DEPTH, 4: entries per FIFO; power of two, at least 2.
- IN_ADDR, 16'hFFF0: read pops the RX FIFO.
- STAT_ADDR, 16'hFFF2: status read, write-1-to-clear.
- OUT_ADDR, 16'hFFF4: write pushes the TX FIFO.

Ports:
- CLK  in  1  clock; all state is rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- bus_addr  in  16  processor data address.
- bus_wdata  in  16  processor store data.
- bus_we  in  1  store strobe, one cycle per access.
- bus_re  in  1  load strobe, one cycle per access.
- bus_hit  out  1  combinational; high when bus_addr equals any of the three addresses.
- bus_rdata  out  16  registered load data.
- host_in_data  in  16  word from host.
- host_in_valid  in  1  host offers a word.
- host_in_ready  out  1  equals !rx_full.
- host_out_data  out  16  head of the TX FIFO.
- host_out_valid  out  1  equals !tx_empty.
- host_out_ready  in  1  host accepts the word.
- main_output  out  16  last word written to OUT_ADDR, including dropped words.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - Both FIFOs are emptied and both sticky flags cleared.
  - bus_rdata = 0, main_output = 0, host_out_valid = 0, host_in_ready = 1.
- Host RX handshake:
  - A push occurs on an edge where host_in_valid && host_in_ready.
  - host_in_ready is driven from the registered count. A push into a full FIFO cannot happen; there is no same-cycle bypass.
  - If host_in_valid is high while the RX FIFO is full, the word is not accepted and rx_ovf is set. The host must hold the word.
- Host TX handshake:
  - A pop occurs on an edge where host_out_valid && host_out_ready.
  - host_out_data is the FIFO head (combinational from storage). It holds steady while valid is high and ready is low.
- Bus loads:
  - bus_rdata is valid exactly one cycle after bus_re. It is a registered output and holds its value until the next load.
  - IN_ADDR load, RX not empty: returns the head word and pops it.
  - IN_ADDR load, RX empty: returns 16'h0000, no pop, no flag change.
  - STAT_ADDR load returns:
    - bit0 = rx_nonempty
    - bit1 = tx_full
    - bit2 = rx_ovf
    - bit3 = tx_drop
    - bits[15:8] = rx_count zero-extended
    - all other bits 0
  - A load from any unmapped address returns 16'h0000.
- Bus stores:
  - OUT_ADDR store, TX not full: pushes bus_wdata.
  - OUT_ADDR store, TX full: the word is dropped and tx_drop is set. Fullness is evaluated at cycle start, so a same-cycle host pop does not rescue the word.
  - Any OUT_ADDR store updates main_output, whether or not the word was pushed.
  - STAT_ADDR store: bus_wdata bit2 = 1 clears rx_ovf; bit3 = 1 clears tx_drop. If a set and a clear hit the same flag in the same cycle, the set wins.
  - Stores to IN_ADDR or unmapped addresses are ignored.
- bus_we and bus_re in the same cycle:
  - The store executes; the load is suppressed.
  - bus_rdata is loaded with 0 and no RX pop occurs.
- Simultaneous FIFO push and pop:
  - Both occur; the count is unchanged.
  - Allowed whenever the FIFO is non-empty and not full.
- Pointer and count rules:
  - Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - The count is log2(DEPTH)+1 bits wide.
  - full is count == DEPTH; empty is count == 0.
- There is no controller state machine beyond the FIFO counters and sticky flags. All decode is single-cycle.

Decomposition:
- Shared package mmio_pkg holds:
  - the default address constants IN_ADDR, STAT_ADDR and OUT_ADDR;
  - the status bit index constants ST_RXNE=0, ST_TXFULL=1, ST_RXOVF=2, ST_TXDROP=3 and ST_CNT_LSB=8.
- One sub-module, io_fifo:
  - parameters DEPTH and WIDTH=16;
  - ports push, pop, din, dout, full, empty, count;
  - CLK and asynchronous active-high Reset.
- mmio_io_port instantiates io_fifo twice (RX and TX) and adds the bus decode, bus_rdata register, sticky flags and main_output register.

Test Plan:
- Host pushes 16'h1234 then 16'h5678; CPU loads IN_ADDR twice -> bus_rdata = 16'h1234 then 16'h5678, one cycle after each bus_re. A third load returns 16'h0000 and STAT bit0 = 0.
- Host pushes 5 words with DEPTH=4 -> host_in_ready = 0 after the fourth push and STAT bit2 = 1. Storing 16'h0004 to STAT_ADDR -> bit2 = 0; FIFO contents are intact.
- CPU stores 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE to OUT_ADDR with host_out_ready = 0 -> STAT = 16'h000A, main_output = 16'hEEEE. Host drains and gets AAAA, BBBB, CCCC, DDDD.
- TX full, CPU store 16'h9999 in the same cycle as a host pop -> 9999 is dropped and tx_drop = 1. Afterwards host_out_valid stays high with 3 entries.
- Assert Reset asynchronously mid-stream with 2 RX and 3 TX entries held -> bus_rdata, main_output and host_out_valid go to 0 immediately without a clock edge. STAT reads 16'h0000 after release.
- Sustained simultaneous host push and CPU pop over 20 cycles -> rx_count stays constant and words emerge in order across pointer wrap-around.
